// File: rtl/mac_pkg.sv
// Shared constants and the saturation-limit helper for the parametrised MAC accumulator.
package mac_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 20;

  // Returned LSB-aligned in 64 bits; the caller keeps the low acc_w bits.
  function automatic logic [63:0] sat_limit(input int acc_w, input bit is_signed, input bit negative);
    logic [63:0] one;
    one = 64'd1;
    if (!is_signed)
      return (one << acc_w) - one;
    else if (negative)
      return one << (acc_w - 1);
    else
      return (one << (acc_w - 1)) - one;
  endfunction

endpackage

// File: rtl/mac_pipe_reg.sv
// Enabled pipeline register with synchronous active-high reset.
module mac_pipe_reg
  import mac_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mac_acc_param.sv
// Three-stage multiply-accumulate with sticky overflow flag.
// Define MAC_SAT_EN to clamp overflowing results instead of wrapping.
module mac_acc_param
  import mac_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             valid_in,
  input  logic             clear_in,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             overflow
);

  localparam int PW = 2 * IN_W;

  generate
    if (ACC_W < PW) begin : g_width_check
      $error("mac_acc_param: ACC_W must be at least 2*IN_W");
    end
  endgenerate

  logic          v1, v2, clr1, clr2;
  logic [PW:0]   s1_d, s1_q, s2_d, s2_q;
  logic [IN_W-1:0] a1, b1;
  logic [PW-1:0] a_x, b_x, prod, p2;

  assign s1_d = {a, b, clear_in};
  assign a1   = s1_q[PW:IN_W+1];
  assign b1   = s1_q[IN_W:1];
  assign clr1 = s1_q[0];

  mac_pipe_reg #(.W(PW + 1)) u_s1_data  (.clk(clk), .reset(reset), .en(valid_in), .d(s1_d), .q(s1_q));
  mac_pipe_reg #(.W(1))      u_s1_valid (.clk(clk), .reset(reset), .en(1'b1),     .d(valid_in), .q(v1));

  // Extending both operands to the product width makes one truncated multiply exact in either mode.
  always_comb begin
    a_x  = (SIGNED != 0) ? PW'($signed(a1)) : PW'(a1);
    b_x  = (SIGNED != 0) ? PW'($signed(b1)) : PW'(b1);
    prod = a_x * b_x;
  end

  assign s2_d = {prod, clr1};
  assign p2   = s2_q[PW:1];
  assign clr2 = s2_q[0];

  mac_pipe_reg #(.W(PW + 1)) u_s2_data  (.clk(clk), .reset(reset), .en(v1),   .d(s2_d), .q(s2_q));
  mac_pipe_reg #(.W(1))      u_s2_valid (.clk(clk), .reset(reset), .en(1'b1), .d(v1),   .q(v2));

  logic [ACC_W-1:0] base, addend, result;
  logic [ACC_W:0]   sum;
  logic             ovf;
`ifdef MAC_SAT_EN
  logic [ACC_W-1:0] limit;
`endif

  // Signed overflow can only happen when both addends share a sign, so base's sign gives the clamp direction.
  always_comb begin
    base   = clr2 ? '0 : f;
    addend = (SIGNED != 0) ? ACC_W'($signed(p2)) : ACC_W'(p2);
    sum    = {1'b0, base} + {1'b0, addend};
    if (SIGNED != 0)
      ovf = (base[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    else
      ovf = sum[ACC_W];
`ifdef MAC_SAT_EN
    limit  = ACC_W'(sat_limit(ACC_W, SIGNED != 0, base[ACC_W-1]));
    result = ovf ? limit : sum[ACC_W-1:0];
`else
    result = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= v2;
      if (v2) begin
        f        <= result;
        overflow <= clr2 ? ovf : (overflow | ovf);
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_param.sv
// Self-checking bench: unsigned and signed instances against an integer-arithmetic reference model.
module tb_mac_acc_param;

  localparam int    ACC_W = 20;
  localparam longint MOD  = 64'd1 << ACC_W;
  localparam longint MAXU = MOD - 1;
  localparam longint MAXS = (MOD / 2) - 1;
  localparam longint MINS = -(MOD / 2);
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, valid_in, clear_in;
  logic [7:0]       a, b;
  logic [ACC_W-1:0] f_u, f_s;
  logic             valid_out_u, valid_out_s, overflow_u, overflow_s;

  always #5 clk = ~clk;

  mac_acc_param u_dut_u (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_u), .valid_out(valid_out_u), .overflow(overflow_u)
  );

  mac_acc_param #(.SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_s), .valid_out(valid_out_s), .overflow(overflow_s)
  );

  typedef struct {
    int               due;
    logic [ACC_W-1:0] fu, fs;
    bit               ou, os;
  } exp_t;

  exp_t   exp_q[$];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  longint acc_u = 0, acc_s = 0;
  bit     ovf_u = 0, ovf_s = 0;
  logic [ACC_W+1:0] hold_u = '0, hold_s = '0, exp_u = '0, exp_s = '0;

  // Reference: true mathematical sum, then range test, then wrap or clamp.
  task automatic model_accept(input bit clr, input logic [7:0] aa, input logic [7:0] bb);
    longint tu, ts, r;
    bit     ou, os;
    exp_t   e;
    tu = (clr ? 0 : acc_u) + longint'(aa) * longint'(bb);
    ts = (clr ? 0 : acc_s) + longint'($signed(aa)) * longint'($signed(bb));
    ou = tu > MAXU;
    os = (ts > MAXS) || (ts < MINS);
    if (SAT) begin
      acc_u = ou ? MAXU : tu;
      acc_s = (ts > MAXS) ? MAXS : ((ts < MINS) ? MINS : ts);
    end else begin
      acc_u = tu % MOD;
      r = ts % MOD;
      if (r < 0) r += MOD;
      if (r > MAXS) r -= MOD;
      acc_s = r;
    end
    ovf_u = clr ? ou : (ovf_u | ou);
    ovf_s = clr ? os : (ovf_s | os);
    e.due = cyc + 2;
    e.fu  = acc_u[ACC_W-1:0];
    e.fs  = acc_s[ACC_W-1:0];
    e.ou  = ovf_u;
    e.os  = ovf_s;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit v, input bit clr, input logic [7:0] aa, input logic [7:0] bb);
    exp_t e;
    reset = rst; valid_in = v; clear_in = clr; a = aa; b = bb;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      acc_u = 0; acc_s = 0; ovf_u = 0; ovf_s = 0;
      hold_u = '0; hold_s = '0; exp_u = '0; exp_s = '0;
    end else begin
      if (v) model_accept(clr, aa, bb);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        hold_u = {1'b0, e.ou, e.fu};
        hold_s = {1'b0, e.os, e.fs};
        exp_u  = {1'b1, e.ou, e.fu};
        exp_s  = {1'b1, e.os, e.fs};
      end else begin
        exp_u = hold_u;
        exp_s = hold_s;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 8'd9, 8'd9);
    drive(1, 1, 1, 8'd7, 8'd7);
    vectors++;
    if ({valid_out_u, overflow_u, f_u} !== '0) begin
      miscompares++;
      $display("FAIL reset_u: got %h want 0", {valid_out_u, overflow_u, f_u});
    end
    vectors++;
    if ({valid_out_s, overflow_s, f_s} !== '0) begin
      miscompares++;
      $display("FAIL reset_s: got %h want 0", {valid_out_s, overflow_s, f_s});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[8] = '{21, 36, 0, 0, 64, 0, 0, 0};
    bit         vv[8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    logic [ACC_W-1:0] fw[8] = '{0, 0, 441, 1737, 1737, 1737, 5833, 5833};
    bit         ow[8] = '{0, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      drive(0, vv[i], 0, av[i], av[i]);
      vectors++;
      if ({valid_out_u, overflow_u, f_u} !== exp_u || {valid_out_s, overflow_s, f_s} !== exp_s) begin
        miscompares++;
        $display("FAIL b2b_model cyc %0d: got u=%h s=%h want u=%h s=%h", i,
                 {valid_out_u, overflow_u, f_u}, {valid_out_s, overflow_s, f_s}, exp_u, exp_s);
      end
      if (i >= 2) begin
        vectors++;
        if (valid_out_u !== ow[i] || f_u !== fw[i]) begin
          miscompares++;
          $display("FAIL b2b_const cyc %0d: got vo=%b f=%0d want vo=%b f=%0d", i, valid_out_u, f_u, ow[i], fw[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    drive(0, 0, 1, 8'd99, 8'd99);
    drive(0, 1, 1, 8'd3, 8'd4);
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if (valid_out_u !== 1'b0 || f_u !== 20'd5833) begin
      miscompares++;
      $display("FAIL clear_ignored: got vo=%b f=%0d want vo=0 f=5833", valid_out_u, f_u);
    end
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if ({valid_out_u, overflow_u, f_u} !== {1'b1, 1'b0, 20'd12} || {valid_out_s, overflow_s, f_s} !== exp_s) begin
      miscompares++;
      $display("FAIL clear_restart: got u=%h s=%h want u=%h s=%h",
               {valid_out_u, overflow_u, f_u}, {valid_out_s, overflow_s, f_s}, {1'b1, 1'b0, 20'd12}, exp_s);
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] want17;
    want17 = SAT ? 20'd1048575 : 20'd56849;
    drive(1, 0, 0, 8'd0, 8'd0);
    for (int i = 0; i < 19; i++) begin
      drive(0, i < 17, 0, 8'd255, 8'd255);
      vectors++;
      if ({valid_out_u, overflow_u, f_u} !== exp_u || {valid_out_s, overflow_s, f_s} !== exp_s) begin
        miscompares++;
        $display("FAIL ovf_model step %0d: got u=%h s=%h want u=%h s=%h", i,
                 {valid_out_u, overflow_u, f_u}, {valid_out_s, overflow_s, f_s}, exp_u, exp_s);
      end
      if (i == 17) begin
        vectors++;
        if (overflow_u !== 1'b0 || f_u !== 20'd1040400) begin
          miscompares++;
          $display("FAIL ovf_16th: got ovf=%b f=%0d want ovf=0 f=1040400", overflow_u, f_u);
        end
      end
    end
    vectors++;
    if (valid_out_u !== 1'b1 || overflow_u !== 1'b1 || f_u !== want17) begin
      miscompares++;
      $display("FAIL ovf_17th: got vo=%b ovf=%b f=%0d want vo=1 ovf=1 f=%0d", valid_out_u, overflow_u, f_u, want17);
    end
    drive(0, 1, 0, 8'd1, 8'd1);
    drive(0, 1, 1, 8'd1, 8'd1);
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if (overflow_u !== 1'b1 || valid_out_u !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got ovf=%b vo=%b want ovf=1 vo=1", overflow_u, valid_out_u);
    end
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if ({valid_out_u, overflow_u, f_u} !== {1'b1, 1'b0, 20'd1}) begin
      miscompares++;
      $display("FAIL ovf_cleared: got %h want %h", {valid_out_u, overflow_u, f_u}, {1'b1, 1'b0, 20'd1});
    end
  endtask

  task automatic test_signed();
    logic signed [ACC_W-1:0] w1, w2;
    w1 = -20'sd16256;
    w2 = -20'sd16271;
    drive(1, 0, 0, 8'd0, 8'd0);
    drive(0, 1, 0, 8'h80, 8'h7F);
    drive(0, 1, 0, 8'hFB, 8'h03);
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if ({valid_out_s, overflow_s, f_s} !== {1'b1, 1'b0, w1}) begin
      miscompares++;
      $display("FAIL signed_1: got vo=%b ovf=%b f=%0d want f=%0d", valid_out_s, overflow_s, $signed(f_s), w1);
    end
    drive(0, 0, 0, 8'd0, 8'd0);
    vectors++;
    if ({valid_out_s, overflow_s, f_s} !== {1'b1, 1'b0, w2} || {valid_out_u, overflow_u, f_u} !== exp_u) begin
      miscompares++;
      $display("FAIL signed_2: got vo=%b ovf=%b f=%0d want f=%0d; u=%h want %h", valid_out_s, overflow_s,
               $signed(f_s), w2, {valid_out_u, overflow_u, f_u}, exp_u);
    end
  endtask

  task automatic test_reset_inflight();
    drive(0, 1, 0, 8'd10, 8'd10);
    drive(0, 1, 0, 8'd20, 8'd20);
    drive(1, 1, 0, 8'd30, 8'd30);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 8'd0, 8'd0);
      vectors++;
      if ({valid_out_u, overflow_u, f_u} !== '0 || {valid_out_s, overflow_s, f_s} !== '0) begin
        miscompares++;
        $display("FAIL reset_inflight cyc %0d: got u=%h s=%h want 0", i,
                 {valid_out_u, overflow_u, f_u}, {valid_out_s, overflow_s, f_s});
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pick[4] = '{8'hFF, 8'h80, 8'h7F, 8'h01};
    logic [7:0] ra, rb;
    bit         rst, rv, rc;
    for (int i = 0; i < 600; i++) begin
      ra  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rc  = ($urandom_range(0, 24) == 0);
      drive(rst, rv, rc, ra, rb);
      vectors++;
      if ({valid_out_u, overflow_u, f_u} !== exp_u || {valid_out_s, overflow_s, f_s} !== exp_s) begin
        miscompares++;
        $display("FAIL random cyc %0d: got u=%h s=%h want u=%h s=%h", i,
                 {valid_out_u, overflow_u, f_u}, {valid_out_s, overflow_s, f_s}, exp_u, exp_s);
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; clear_in = 1'b0; a = '0; b = '0;
    test_reset();
    test_back_to_back();
    test_clear();
    test_overflow();
    test_signed();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
